// File: rtl/l5_trk_result_packer_if.sv
// AXI-Stream bundle carrying packed tracking results from the packer to the PS-side DMA/FIFO.
interface l5_trk_result_packer_if #(
  parameter int INPUT_WIDTH = 32
) ();
  logic [INPUT_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/l5_trk_result_packer.sv
// Snapshots the L5/E5 correlator dump on each ready rise and streams it as an 11-beat
// AXI-Stream packet (header, sample count, E/P/L/Pilot I/Q) with epoch and overrun accounting.
module l5_trk_result_packer #(
  parameter int INPUT_WIDTH = 32,
  parameter int EPOCH_WIDTH = 16
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  input  logic                          i_ready,
  input  logic [2*INPUT_WIDTH-1:0]      i_data_count,
  input  logic signed [INPUT_WIDTH-1:0] i_iE,
  input  logic signed [INPUT_WIDTH-1:0] i_qE,
  input  logic signed [INPUT_WIDTH-1:0] i_iP,
  input  logic signed [INPUT_WIDTH-1:0] i_qP,
  input  logic signed [INPUT_WIDTH-1:0] i_iL,
  input  logic signed [INPUT_WIDTH-1:0] i_qL,
  input  logic signed [INPUT_WIDTH-1:0] i_iPilot,
  input  logic signed [INPUT_WIDTH-1:0] i_qPilot,
  l5_trk_result_packer_if.master        m_axis,
  output logic                          o_busy,
  output logic [15:0]                   o_overrun_count
);

  localparam logic [3:0] LAST_BEAT = 4'd10;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                        state;
  logic                          r_ready;
  logic                          rise;
  logic                          hs;
  logic                          sticky;
  logic                          capture;
  logic [3:0]                    beat_idx;
  logic [3:0]                    next_idx;
  logic [2:0]                    word_sel;
  logic [EPOCH_WIDTH-1:0]        epoch;
  logic [INPUT_WIDTH-1:0]        next_word;
  logic [2*INPUT_WIDTH-1:0]      cnt_p0;
  logic signed [INPUT_WIDTH-1:0] snap_p0 [8];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [INPUT_WIDTH-1:0] header_word(input logic [EPOCH_WIDTH-1:0] ep,
                                                         input logic flag);
    logic [INPUT_WIDTH-1:0] w;
    w = '0;
    w[16 +: EPOCH_WIDTH] = ep;
    w[15:8] = 8'h5E;
    w[0] = flag;
    return w;
  endfunction

  assign rise     = i_ready & ~r_ready;
  assign hs       = m_axis.tvalid & m_axis.tready;
  assign capture  = (state == ST_IDLE) & rise;
  assign next_idx = beat_idx + 4'd1;
  assign word_sel = 3'(next_idx - 4'd3);

  // Beat source for the word following the one currently on the bus
  always_comb begin
    next_word = '0;
    case (next_idx)
      4'd1:    next_word = cnt_p0[INPUT_WIDTH-1:0];
      4'd2:    next_word = cnt_p0[2*INPUT_WIDTH-1:INPUT_WIDTH];
      default: next_word = snap_p0[word_sel];
    endcase
  end

  // p0: snapshot bank, written only from IDLE so an in-flight packet is never disturbed
  always_ff @(posedge axis_aclk) begin
    if (capture) begin
      cnt_p0     <= i_data_count;
      snap_p0[0] <= i_iE;
      snap_p0[1] <= i_qE;
      snap_p0[2] <= i_iP;
      snap_p0[3] <= i_qP;
      snap_p0[4] <= i_iL;
      snap_p0[5] <= i_qL;
      snap_p0[6] <= i_iPilot;
      snap_p0[7] <= i_qPilot;
    end
  end

  // p1: registered stream beat plus packet control
  always_ff @(posedge axis_aclk) begin
    if (axis_aresetn) begin
      state           <= ST_IDLE;
      r_ready         <= 1'b1;
      beat_idx        <= '0;
      epoch           <= '0;
      sticky          <= 1'b0;
      o_overrun_count <= '0;
      o_busy          <= 1'b0;
      m_axis.tvalid   <= 1'b0;
      m_axis.tlast    <= 1'b0;
      m_axis.tdata    <= '0;
    end else begin
      r_ready <= i_ready;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            beat_idx      <= '0;
            m_axis.tdata  <= header_word(epoch, sticky);
            m_axis.tlast  <= 1'b0;
            m_axis.tvalid <= 1'b1;
            o_busy        <= 1'b1;
            state         <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (rise) begin
            o_overrun_count <= sat_inc(o_overrun_count);
          end
          // A drop in the same cycle as the header handshake keeps the flag set
          if (rise) begin
            sticky <= 1'b1;
          end else if (hs && beat_idx == 4'd0) begin
            sticky <= 1'b0;
          end
          if (hs) begin
            if (beat_idx == LAST_BEAT) begin
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              o_busy        <= 1'b0;
              epoch         <= epoch + EPOCH_WIDTH'(1);
              state         <= ST_IDLE;
            end else begin
              beat_idx     <= next_idx;
              m_axis.tdata <= next_word;
              m_axis.tlast <= (next_idx == LAST_BEAT);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l5_trk_result_packer.sv
// Bench for l5_trk_result_packer: directed scenarios plus randomized traffic against a packet-queue model.
module tb_l5_trk_result_packer;
  localparam int W = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rdy = 1'b0;
  logic [2*W-1:0]       cnt = '0;
  logic signed [W-1:0]  w [8];
  logic                 o_busy;
  logic [15:0]          ovr;
  int                   n_chk = 0;
  int                   n_fail = 0;

  l5_trk_result_packer_if #(.INPUT_WIDTH(W)) s ();

  l5_trk_result_packer #(.INPUT_WIDTH(W), .EPOCH_WIDTH(16)) dut (
    .axis_aclk(clk), .axis_aresetn(rst), .i_ready(rdy), .i_data_count(cnt),
    .i_iE(w[0]), .i_qE(w[1]), .i_iP(w[2]), .i_qP(w[3]),
    .i_iL(w[4]), .i_qL(w[5]), .i_iPilot(w[6]), .i_qPilot(w[7]),
    .m_axis(s), .o_busy(o_busy), .o_overrun_count(ovr)
  );

  always #5 clk = ~clk;

  // Accepted beats and completed packets, as seen by the downstream consumer
  logic [W-1:0] got [$];
  int           npk = 0;
  always @(posedge clk) begin
    if (!rst && s.tvalid && s.tready) begin
      got.push_back(s.tdata);
      if (s.tlast) npk++;
    end
  end

  // Reference: a dump becomes a queue of 11 words; the bus presents the queue head
  logic [W-1:0] mq [$];
  logic         m_prev = 1'b1;
  logic         m_rise;
  logic [15:0]  m_epoch = '0;
  logic         m_flag = 1'b0;
  logic [15:0]  m_ovr = '0;
  logic         m_valid = 1'b0;
  logic         m_last = 1'b0;
  logic [W-1:0] m_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev = 1'b1; m_epoch = '0; m_flag = 1'b0; m_ovr = '0;
    end else begin
      m_rise = rdy && !m_prev;
      m_prev = rdy;
      if (mq.size() != 0) begin
        if (s.tready) begin
          if (mq.size() == 11) m_flag = 1'b0;
          void'(mq.pop_front());
          if (mq.size() == 0) m_epoch = m_epoch + 16'd1;
        end
        if (m_rise) begin
          m_flag = 1'b1;
          if (m_ovr != 16'hFFFF) m_ovr = m_ovr + 16'd1;
        end
      end else if (m_rise) begin
        mq.push_back({m_epoch, 8'h5E, 7'd0, m_flag});
        mq.push_back(cnt[W-1:0]);
        mq.push_back(cnt[2*W-1:W]);
        for (int i = 0; i < 8; i++) mq.push_back(w[i]);
      end
    end
    m_valid = (mq.size() != 0);
    m_data  = m_valid ? mq[0] : '0;
    m_last  = (mq.size() == 1);
  end

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b0; s.tready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got.delete(); npk = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    cnt = {$urandom, $urandom};
  endtask

  task automatic wait_pkts(input int target, input int budget, output bit ok);
    for (int c = 0; c < budget && npk < target; c++) @(negedge clk);
    ok = (npk >= target);
  endtask

  task automatic set_fixed_payload();
    cnt = 64'h0000_0001_0000_0ABC;
    for (int i = 0; i < 8; i++) w[i] = (i + 1) * 32'h11;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; s.tready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (s.tvalid !== 1'b0 || s.tlast !== 1'b0 || s.tdata !== '0 || o_busy !== 1'b0 || ovr !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b data=%h busy=%b ovr=%0d, required all zero",
               s.tvalid, s.tlast, s.tdata, o_busy, ovr);
    end
    rst = 1'b0; npk = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if (s.tvalid !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL held_high_release: cycle %0d valid=%b busy=%b, required 0", c, s.tvalid, o_busy);
      end
    end
    rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_b [11];
    exp_b[0] = 32'h0000_5E00; exp_b[1] = 32'h0000_0ABC; exp_b[2] = 32'h0000_0001;
    for (int i = 0; i < 8; i++) exp_b[3+i] = (i + 1) * 32'h11;
    do_reset();
    set_fixed_payload();
    rdy = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s.tvalid !== 1'b1 || o_busy !== 1'b1 || s.tdata !== 32'h0000_5E00) begin
      n_fail++;
      $display("FAIL first_beat_latency: valid=%b busy=%b data=%h, required 1 1 00005e00", s.tvalid, o_busy, s.tdata);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_chk++;
      if (s.tvalid !== m_valid || o_busy !== m_valid || ovr !== m_ovr ||
          (m_valid && (s.tdata !== m_data || s.tlast !== m_last))) begin
        n_fail++;
        $display("FAIL basic_cycle: v=%b d=%h l=%b ovr=%0d, required v=%b d=%h l=%b ovr=%0d",
                 s.tvalid, s.tdata, s.tlast, ovr, m_valid, m_data, m_last, m_ovr);
      end
    end
    n_chk++;
    if (got.size() != 11 || npk != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_count: beats=%0d pkts=%0d busy=%b, required 11 1 0", got.size(), npk, o_busy);
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_chk++;
        if (got[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL basic_beat%0d: got %h required %h", i, got[i], exp_b[i]);
        end
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_b [11];
    logic         pv, pr, pl;
    logic [W-1:0] pd;
    bit           ok;
    exp_b[0] = 32'h0000_5E00; exp_b[1] = 32'h0000_0ABC; exp_b[2] = 32'h0000_0001;
    for (int i = 0; i < 8; i++) exp_b[3+i] = (i + 1) * 32'h11;
    do_reset();
    set_fixed_payload();
    rdy = 1'b1;
    for (int c = 0; c < 200 && npk == 0; c++) begin
      s.tready = 1'($urandom_range(0, 1));
      pv = s.tvalid; pr = s.tready; pd = s.tdata; pl = s.tlast;
      @(negedge clk);
      if (pv && !pr) begin
        n_chk++;
        if (s.tvalid !== 1'b1 || s.tdata !== pd || s.tlast !== pl) begin
          n_fail++;
          $display("FAIL stall_stable: v=%b d=%h l=%b, required 1 %h %b", s.tvalid, s.tdata, s.tlast, pd, pl);
        end
      end
      n_chk++;
      if (s.tvalid !== m_valid || (m_valid && (s.tdata !== m_data || s.tlast !== m_last))) begin
        n_fail++;
        $display("FAIL stall_cycle: v=%b d=%h l=%b, required v=%b d=%h l=%b",
                 s.tvalid, s.tdata, s.tlast, m_valid, m_data, m_last);
      end
    end
    ok = (npk == 1 && got.size() == 11);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_complete: pkts=%0d beats=%0d, required 1 11", npk, got.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        n_chk++;
        if (got[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL stall_beat%0d: got %h required %h", i, got[i], exp_b[i]);
        end
      end
    end
    s.tready = 1'b1; rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    logic [W-1:0] save0 [8];
    bit           ok;
    do_reset();
    rand_payload();
    for (int i = 0; i < 8; i++) save0[i] = w[i];
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 40 && got.size() < 4; c++) @(negedge clk);
    s.tready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (s.tvalid !== 1'b1 || s.tdata !== save0[1]) begin
      n_fail++;
      $display("FAIL ovr_beat4_stalled: v=%b d=%h, required 1 %h", s.tvalid, s.tdata, save0[1]);
    end
    rdy = 1'b1;
    rand_payload();
    @(negedge clk);
    n_chk++;
    if (ovr !== 16'd1) begin
      n_fail++;
      $display("FAIL ovr_count: got %0d required 1", ovr);
    end
    rdy = 1'b0;
    @(negedge clk);
    s.tready = 1'b1;
    wait_pkts(1, 40, ok);
    n_chk++;
    if (!ok || got.size() != 11 || got[0] !== 32'h0000_5E00) begin
      n_fail++;
      $display("FAIL ovr_pkt0: ok=%b beats=%0d hdr=%h, required 1 11 00005e00", ok, got.size(), got[0]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (got[3+i] !== save0[i]) begin
          n_fail++;
          $display("FAIL ovr_snapshot%0d: got %h required %h", i, got[3+i], save0[i]);
        end
      end
    end
    rdy = 1'b1;
    wait_pkts(2, 40, ok);
    n_chk++;
    if (!ok || got.size() != 22 || got[11] !== 32'h0001_5E01) begin
      n_fail++;
      $display("FAIL ovr_pkt1_hdr: ok=%b beats=%0d hdr=%h, required 1 22 00015e01", ok, got.size(), got[11]);
    end
    rdy = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    wait_pkts(3, 40, ok);
    n_chk++;
    if (!ok || got.size() != 33 || got[22] !== 32'h0002_5E00) begin
      n_fail++;
      $display("FAIL ovr_pkt2_hdr: ok=%b beats=%0d hdr=%h, required 1 33 00025e00", ok, got.size(), got[22]);
    end
    rdy = 1'b0;
  endtask

  task automatic test_last_rise();
    do_reset();
    rand_payload();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 40 && !(s.tvalid && s.tlast); c++) @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ovr !== 16'd1 || s.tvalid !== 1'b0 || npk != 1) begin
      n_fail++;
      $display("FAIL last_rise_drop: ovr=%0d v=%b pkts=%0d, required 1 0 1", ovr, s.tvalid, npk);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (s.tvalid !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL last_rise_idle: cycle %0d v=%b busy=%b, required 0 0", c, s.tvalid, o_busy);
      end
    end
    rdy = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    rand_payload();
    rdy = 1'b1;
    repeat (500) @(negedge clk);
    n_chk++;
    if (npk != 1 || got.size() != 11 || s.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_high: pkts=%0d beats=%0d v=%b, required 1 11 0", npk, got.size(), s.tvalid);
    end
    rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rand_payload();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    for (int c = 0; c < 40 && got.size() < 2; c++) @(negedge clk);
    rdy = 1'b1;
    for (int c = 0; c < 40 && got.size() < 6; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s.tvalid !== 1'b0 || o_busy !== 1'b0 || ovr !== 16'd0 || s.tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b busy=%b ovr=%0d l=%b, required 0 0 0 0", s.tvalid, o_busy, ovr, s.tlast);
    end
    rst = 1'b0; rdy = 1'b0;
    @(negedge clk);
    got.delete(); npk = 0;
    rdy = 1'b1;
    wait_pkts(1, 40, ok);
    n_chk++;
    if (!ok || got.size() != 11 || got[0] !== 32'h0000_5E00 || ovr !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_next: ok=%b beats=%0d hdr=%h ovr=%0d, required 1 11 00005e00 0",
               ok, got.size(), got[0], ovr);
    end
    rdy = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) rdy = ~rdy;
      s.tready = ($urandom_range(0, 3) != 0);
      rand_payload();
      @(negedge clk);
      n_chk++;
      if (s.tvalid !== m_valid || o_busy !== m_valid || ovr !== m_ovr ||
          (m_valid && (s.tdata !== m_data || s.tlast !== m_last))) begin
        n_fail++;
        $display("FAIL random_cycle%0d: v=%b d=%h l=%b ovr=%0d, required v=%b d=%h l=%b ovr=%0d",
                 c, s.tvalid, s.tdata, s.tlast, ovr, m_valid, m_data, m_last, m_ovr);
      end
    end
    s.tready = 1'b1; rdy = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) w[i] = '0;
    s.tready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_last_rise();
    test_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l5_trk_result_packer.md
Name: l5_trk_result_packer

Overview:
- Downstream consumer of the L5/E5 tracking correlator.
- On each rising edge of the correlator's ready flag, it snapshots the eight correlator outputs (E/P/L/Pilot I/Q) and the 64-bit sample count.
- Emits the snapshot as one 11-beat AXI-Stream packet to the PS-side DMA/FIFO, with backpressure, epoch numbering and overrun accounting.
- Decouples PS readout timing from the correlator's ST_IDLE4 dwell.

Parameters:
- INPUT_WIDTH, 32, width of each correlator word and of the output stream beat.
- EPOCH_WIDTH, 16, width of the packet epoch counter; must be ≤ INPUT_WIDTH-16.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  reset; synchronous, active-high.
- i_ready  in  1  correlator ready/dump flag; level signal, only rising edge is used.
- i_data_count  in  2*INPUT_WIDTH  sample count at dump.
- i_iE, i_qE, i_iP, i_qP, i_iL, i_qL, i_iPilot, i_qPilot  in  INPUT_WIDTH each  correlator results.
- m_axis_tdata  out  INPUT_WIDTH  stream beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last beat of packet.
- o_busy  out  1  packet in flight.
- o_overrun_count  out  16  saturating count of dropped dumps.

Behaviour:
- Reset values, synchronously on axis_aresetn=1:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_busy=0, o_overrun_count=0.
  - Epoch=0, beat index=0, sticky overrun flag=0, state=IDLE.
  - Ready-delay register r_ready=1, so a level-high i_ready at reset release does NOT trigger a packet.
- Edge detect: rise = i_ready & ~r_ready; r_ready <= i_ready every cycle.
- State IDLE:
  - On rise at edge N, capture the 8 words plus i_data_count into a snapshot register bank.
  - Set beat index=0, go to SEND. m_axis_tvalid=1 and o_busy=1 are visible from cycle N+1.
  - Latency from rise to first valid beat is 1 cycle.
- State SEND:
  - m_axis_tvalid held at 1. tdata and tlast are registered and stable while tvalid=1 and tready=0.
  - Each handshake (tvalid & tready) advances the beat index by 1.
  - Handshake on beat 10 returns to IDLE; tvalid=0 the next cycle.
  - Back-to-back handshakes sustain 1 beat/cycle. Minimum packet duration is 11 cycles.
- Beat layout, in order:
  - 0 header: [31:16] epoch, [15:8] 8'h5E sync, [7:1] 0, [0] sticky overrun flag.
  - 1 data_count[31:0].
  - 2 data_count[63:32].
  - 3 iE, 4 qE, 5 iP, 6 qP, 7 iL, 8 qL, 9 iPilot, 10 qPilot.
  - tlast=1 only on beat 10.
- Epoch:
  - Header carries the epoch of the current packet. The first packet after reset carries 0.
  - Epoch increments on the beat-10 handshake and wraps modulo 2^EPOCH_WIDTH.
- Overrun:
  - A rise while in SEND is dropped: no snapshot change, o_overrun_count+1 (saturates at 16'hFFFF), sticky flag set.
  - A rise in the same cycle as the beat-10 handshake is also dropped and counted.
  - The sticky flag appears in the header of the next packet and clears on that header's handshake.
  - A new overrun arriving in the same cycle as that header handshake sets the flag again (set wins).
- Snapshot: never modified while in SEND; input changes after capture have no effect on the packet.
- Reset mid-packet:
  - tvalid drops the cycle after reset is asserted; no tlast is emitted and the partial packet is abandoned.
  - Epoch and overrun state are cleared.
- i_ready held high for many cycles produces exactly one packet. A new packet requires i_ready to fall and rise again.

Test Plan:
- Reset, then i_ready 0→1 with iE=32'h11, qE=32'h22, …, qPilot=32'h88 and data_count=64'h0000_0001_0000_0ABC, tready=1 → tvalid from next cycle; 11 beats: 0x0000_5E00, 0x0000_0ABC, 0x0000_0001, 0x11…0x88; tlast on beat 10 only; o_busy low afterwards.
- Same dump with tready toggling 1-0-0-1 pseudo-randomly → identical beat sequence; tdata/tlast stable during every stall.
- Second rise while beat 4 is stalled → packet 0 unchanged; o_overrun_count=1; next packet header = 0x0001_5E01; the following packet header = 0x0002_5E00.
- Rise exactly on the beat-10 handshake cycle → dropped; o_overrun_count increments; no new packet starts.
- i_ready held high through reset release, and held high for 500 cycles after one rise → zero packets and one packet respectively.
- Reset asserted during beat 6 → tvalid=0 the next cycle; the next dump produces a packet with header epoch 0 and no overrun flag.
